// File: rtl/i2c_bert_burst_sequencer.sv
// i2c_bert_burst_sequencer
// Runs a burst of cfg_count BERT transactions against the I2C BERT engine
// through a req/ack handshake. Between transactions it waits cfg_gap idle
// cycles. It counts completions and errored completions, and reports
// pass/fail with a one-cycle done pulse when the burst ends.
// Build option: define SEQ_WATCHDOG_EN to add a per-transaction watchdog
// limited by cfg_wdog. Without it, cfg_wdog is ignored and timeout stays 0.
module i2c_bert_burst_sequencer #(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned WDOG_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [WDOG_W-1:0]  cfg_wdog,
    output logic               eng_req,
    input  logic               eng_ack,
    input  logic               eng_done,
    input  logic               eng_err,
    output logic               busy,
    output logic               done,
    output logic               status_ok,
    output logic               timeout,
    output logic [COUNT_W-1:0] tx_count,
    output logic [COUNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [COUNT_W-1:0] tx_q, tx_d;
    logic [COUNT_W-1:0] err_q, err_d;
    logic               status_ok_q, status_ok_d;

    // Temporaries used while resolving a transaction completion.
    logic               complete;
    logic [COUNT_W-1:0] tx_inc;
    logic [COUNT_W-1:0] err_inc;

`ifdef SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic               timeout_q, timeout_d;
`else
    logic               unused_wdog;
    assign unused_wdog = ^cfg_wdog;
`endif

    // Next-state, counter, and result logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        tx_d        = tx_q;
        err_d       = err_q;
        status_ok_d = status_ok_q;
        complete    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wdog_d      = wdog_q;
        wdog_cnt_d  = wdog_cnt_q;
        timeout_d   = timeout_q;
`endif
        tx_inc  = tx_q + COUNT_W'(1);
        err_inc = (eng_err && (err_q != '1)) ? err_q + COUNT_W'(1) : err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d     = cfg_count;
                    gap_d       = cfg_gap;
                    tx_d        = '0;
                    err_d       = '0;
                    status_ok_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
                    wdog_d      = cfg_wdog;
                    timeout_d   = 1'b0;
`endif
                    if (cfg_count == '0) begin
                        state_d     = S_FIN;
                        status_ok_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d     = S_FIN;
                    status_ok_d = 1'b0;
                end else if (eng_ack) begin
                    // A done in the same cycle as the ack finishes the transaction now.
                    if (eng_done) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
                        wdog_cnt_d = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d     = S_FIN;
                    status_ok_d = 1'b0;
                end else if (eng_done) begin
                    complete = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                end else if ((wdog_q != '0) && (wdog_cnt_q == wdog_q - WDOG_W'(1))) begin
                    timeout_d   = 1'b1;
                    state_d     = S_FIN;
                    status_ok_d = 1'b0;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
`endif
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d     = S_FIN;
                    status_ok_d = 1'b0;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is decided on entry to FIN, so status_ok is valid with done.
        if (complete) begin
            tx_d  = tx_inc;
            err_d = err_inc;
            if (tx_inc == count_q) begin
                state_d     = S_FIN;
                status_ok_d = (err_inc == '0);
            end else if (gap_q == '0) begin
                state_d = S_ISSUE;
            end else begin
                state_d   = S_GAP;
                gap_cnt_d = gap_q - GAP_W'(1);
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            tx_q        <= '0;
            err_q       <= '0;
            status_ok_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wdog_q      <= '0;
            wdog_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_q        <= tx_d;
            err_q       <= err_d;
            status_ok_q <= status_ok_d;
`ifdef SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
            wdog_cnt_q  <= wdog_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign eng_req   = (state_q == S_ISSUE);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
    assign done      = (state_q == S_FIN);
    assign status_ok = status_ok_q;
    assign tx_count  = tx_q;
    assign err_count = err_q;
`ifdef SEQ_WATCHDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bert_burst_sequencer.sv
// Directed self-checking bench for i2c_bert_burst_sequencer.
// Inputs are driven 1 time unit after posedge; outputs are checked at the same point.
module tb_i2c_bert_burst_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [11:0] cfg_wdog;
    logic        eng_req;
    logic        eng_ack;
    logic        eng_done;
    logic        eng_err;
    logic        busy;
    logic        done;
    logic        status_ok;
    logic        timeout;
    logic [15:0] tx_count;
    logic [15:0] err_count;

    int vecs = 0;
    int miscompares = 0;

    i2c_bert_burst_sequencer #(
        .COUNT_W(16),
        .GAP_W  (8),
        .WDOG_W (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_count(cfg_count),
        .cfg_gap  (cfg_gap),
        .cfg_wdog (cfg_wdog),
        .eng_req  (eng_req),
        .eng_ack  (eng_ack),
        .eng_done (eng_done),
        .eng_err  (eng_err),
        .busy     (busy),
        .done     (done),
        .status_ok(status_ok),
        .timeout  (timeout),
        .tx_count (tx_count),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] cnt, input logic [7:0] gap, input logic [11:0] wd);
        cfg_count = cnt;
        cfg_gap   = gap;
        cfg_wdog  = wd;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Engine model: wait for req, ack one cycle later, done five cycles after the ack.
    task automatic do_txn(input logic err, output int waited);
        waited = 0;
        while (eng_req !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (eng_req !== 1'b1) begin
            vecs++;
            miscompares++;
            $display("FAIL txn_req_wait: eng_req=%b after %0d cycles, expected 1", eng_req, waited);
            return;
        end
        step();
        vecs++;
        if (eng_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_hold: eng_req=%b expected 1 before ack", eng_req);
        end
        eng_ack = 1'b1;
        step();
        eng_ack = 1'b0;
        vecs++;
        if (eng_req !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL req_drop: eng_req=%b busy=%b expected 0/1", eng_req, busy);
        end
        repeat (4) step();
        eng_done = 1'b1;
        eng_err  = err;
        step();
        eng_done = 1'b0;
        eng_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        vecs++;
        if ({eng_req, busy, done, status_ok, timeout} !== 5'b0 || tx_count !== 16'd0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: req/busy/done/ok/to=%b%b%b%b%b tx=%0d err=%0d expected all 0",
                     eng_req, busy, done, status_ok, timeout, tx_count, err_count);
        end
    endtask

    task automatic test_basic();
        int w;
        start_burst(16'd3, 8'd2, 12'd0);
        vecs++;
        if (eng_req !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: eng_req=%b busy=%b expected 1/1", eng_req, busy);
        end
        do_txn(1'b0, w);
        do_txn(1'b0, w);
        vecs++;
        if (w != 2) begin
            miscompares++;
            $display("FAIL basic_gap1: idle=%0d expected 2", w);
        end
        do_txn(1'b0, w);
        vecs++;
        if (w != 2) begin
            miscompares++;
            $display("FAIL basic_gap2: idle=%0d expected 2", w);
        end
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0 || status_ok !== 1'b1 || eng_req !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fin: done=%b busy=%b ok=%b req=%b expected 1/0/1/0", done, busy, status_ok, eng_req);
        end
        vecs++;
        if (tx_count !== 16'd3 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_counts: tx=%0d err=%0d expected 3/0", tx_count, err_count);
        end
        step();
        vecs++;
        if (done !== 1'b0 || status_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after: done=%b ok=%b expected 0/1", done, status_ok);
        end
    endtask

    task automatic test_errors();
        int w;
        start_burst(16'd4, 8'd1, 12'd0);
        vecs++;
        if (status_ok !== 1'b0 || tx_count !== 16'd0) begin
            miscompares++;
            $display("FAIL err_clear: ok=%b tx=%0d expected 0/0", status_ok, tx_count);
        end
        do_txn(1'b0, w);
        do_txn(1'b1, w);
        vecs++;
        if (err_count !== 16'd1 || tx_count !== 16'd2) begin
            miscompares++;
            $display("FAIL err_mid: tx=%0d err=%0d expected 2/1", tx_count, err_count);
        end
        do_txn(1'b0, w);
        vecs++;
        if (w != 1) begin
            miscompares++;
            $display("FAIL err_gap: idle=%0d expected 1", w);
        end
        do_txn(1'b1, w);
        vecs++;
        if (done !== 1'b1 || status_ok !== 1'b0 || tx_count !== 16'd4 || err_count !== 16'd2) begin
            miscompares++;
            $display("FAIL err_fin: done=%b ok=%b tx=%0d err=%0d expected 1/0/4/2", done, status_ok, tx_count, err_count);
        end
        step();
    endtask

    task automatic test_zero();
        eng_done = 1'b1;
        eng_ack  = 1'b1;
        step();
        eng_done = 1'b0;
        eng_ack  = 1'b0;
        vecs++;
        if (tx_count !== 16'd4 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done_ignored: tx=%0d busy=%b expected 4/0", tx_count, busy);
        end
        start_burst(16'd0, 8'd3, 12'd0);
        vecs++;
        if (done !== 1'b1 || status_ok !== 1'b1 || tx_count !== 16'd0 || err_count !== 16'd0 || eng_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_fin: done=%b ok=%b tx=%0d err=%0d req=%b busy=%b expected 1/1/0/0/0/0",
                     done, status_ok, tx_count, err_count, eng_req, busy);
        end
        step();
        vecs++;
        if (done !== 1'b0 || eng_req !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after: done=%b req=%b expected 0/0", done, eng_req);
        end
    endtask

    task automatic test_abort();
        int w;
        int n;
        start_burst(16'd10, 8'd0, 12'd0);
        do_txn(1'b0, w);
        do_txn(1'b0, w);
        vecs++;
        if (w != 0) begin
            miscompares++;
            $display("FAIL abort_nogap: idle=%0d expected 0", w);
        end
        n = 0;
        while (eng_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        eng_ack = 1'b1;
        step();
        eng_ack = 1'b0;
        step();
        eng_done = 1'b1;
        abort    = 1'b1;
        step();
        eng_done = 1'b0;
        abort    = 1'b0;
        vecs++;
        if (done !== 1'b1 || tx_count !== 16'd2 || status_ok !== 1'b0 || eng_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_fin: done=%b tx=%0d ok=%b req=%b busy=%b expected 1/2/0/0/0",
                     done, tx_count, status_ok, eng_req, busy);
        end
        step();
        vecs++;
        if (done !== 1'b0 || eng_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after: done=%b req=%b busy=%b expected 0/0/0", done, eng_req, busy);
        end
    endtask

    task automatic test_watchdog();
        int n;
        start_burst(16'd2, 8'd0, 12'd20);
        eng_ack = 1'b1;
        step();
        eng_ack = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        vecs++;
        if (n != 20 || timeout !== 1'b1 || status_ok !== 1'b0 || tx_count !== 16'd0) begin
            miscompares++;
            $display("FAIL wdog_expire: cycles=%0d timeout=%b ok=%b tx=%0d expected 20/1/0/0", n, timeout, status_ok, tx_count);
        end
        step();
        vecs++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wdog_sticky: timeout=%b busy=%b expected 1/0", timeout, busy);
        end
`else
        n = 0;
        repeat (50) begin
            step();
            if (done === 1'b1) n++;
        end
        vecs++;
        if (busy !== 1'b1 || n != 0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL nowdog_hold: busy=%b done_pulses=%0d timeout=%b expected 1/0/0", busy, n, timeout);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vecs++;
        if (done !== 1'b1 || status_ok !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL nowdog_abort: done=%b ok=%b timeout=%b expected 1/0/0", done, status_ok, timeout);
        end
        step();
`endif
    endtask

    // Done arriving in the 20th WAIT cycle beats a 20-cycle watchdog.
    task automatic test_expiry_done();
        start_burst(16'd1, 8'd0, 12'd20);
        vecs++;
        if (timeout !== 1'b0 || eng_req !== 1'b1) begin
            miscompares++;
            $display("FAIL expiry_start: timeout=%b req=%b expected 0/1", timeout, eng_req);
        end
        eng_ack = 1'b1;
        step();
        eng_ack = 1'b0;
        repeat (19) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        vecs++;
        if (done !== 1'b1 || tx_count !== 16'd1 || timeout !== 1'b0 || status_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL expiry_done_wins: done=%b tx=%0d timeout=%b ok=%b expected 1/1/0/1", done, tx_count, timeout, status_ok);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int w;
        int seen;
        start_burst(16'd3, 8'd5, 12'd0);
        do_txn(1'b0, w);
        step();
        vecs++;
        if (busy !== 1'b1 || eng_req !== 1'b0 || tx_count !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_pre_gap: busy=%b req=%b tx=%0d expected 1/0/1", busy, eng_req, tx_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if ({eng_req, busy, done, status_ok, timeout} !== 5'b0 || tx_count !== 16'd0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_gap_outputs: req/busy/done/ok/to=%b%b%b%b%b tx=%0d err=%0d expected all 0",
                     eng_req, busy, done, status_ok, timeout, tx_count, err_count);
        end
        seen = 0;
        repeat (8) begin
            step();
            if (done === 1'b1 || eng_req === 1'b1) seen++;
        end
        vecs++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL rst_no_done: activity cycles=%0d expected 0", seen);
        end
        start_burst(16'd2, 8'd1, 12'd0);
        do_txn(1'b0, w);
        cfg_count = 16'd0;
        cfg_gap   = 8'd9;
        start     = 1'b1;
        step();
        start     = 1'b0;
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0 || eng_req !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start_ignored: busy=%b done=%b req=%b expected 1/0/1", busy, done, eng_req);
        end
        do_txn(1'b0, w);
        vecs++;
        if (done !== 1'b1 || tx_count !== 16'd2 || status_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_fin: done=%b tx=%0d ok=%b expected 1/2/1", done, tx_count, status_ok);
        end
        step();
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_count = '0;
        cfg_gap   = '0;
        cfg_wdog  = '0;
        eng_ack   = 1'b0;
        eng_done  = 1'b0;
        eng_err   = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_errors();
        test_zero();
        test_abort();
        test_watchdog();
        test_expiry_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
